// File: rtl/alu_exec_stage.sv
// alu_exec_stage -- two-slot execute pipeline stage around an external
// combinational ALU.
//
// Slot A (operand register) captures an issued op and drives the ALU.
// Slot B (result register) captures the ALU result, destination tag and an
// illegal-opcode flag. It presents them to writeback over valid/ready.
// An op accepted in cycle c is loaded into A at the end of c, moves to B at
// the end of c+1, and is visible on out_* during cycle c+2.
//
// Optional feature: define ALU_BYPASS_EN to forward results into the operands
// at accept time. The data comes from the op leaving A (alu_result) or from
// the op held in B (b_result).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             discard both slots at the next edge; blocks issue
//   in_valid/in_ready issue handshake
//   in_opcode, in_op0, in_op1, in_rd, in_rs0, in_rs1   issued op
//   alu_opcode, alu_operand_0, alu_operand_1   to ALU (from slot A)
//   alu_result        from ALU, same cycle
//   out_valid/out_ready writeback handshake
//   out_result, out_rd, out_we, out_illegal    registered result (slot B)
module alu_exec_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [DATA_W-1:0] in_op0,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs0,
  input  logic [REG_AW-1:0] in_rs1,
  output logic [5:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_operand_0,
  output logic [DATA_W-1:0] alu_operand_1,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_illegal
);

  // Slot A
  logic              a_valid_reg;
  logic [5:0]        a_opcode_reg;
  logic [DATA_W-1:0] a_op0_reg;
  logic [DATA_W-1:0] a_op1_reg;
  logic [REG_AW-1:0] a_rd_reg;

  // Slot B
  logic              b_valid_reg;
  logic [DATA_W-1:0] b_result_reg;
  logic [REG_AW-1:0] b_rd_reg;
  logic              b_illegal_reg;

  logic              b_free;
  logic              a_adv;
  logic              accept;
  logic              a_illegal;
  logic [DATA_W-1:0] cap_op0;
  logic [DATA_W-1:0] cap_op1;

  assign b_free   = !b_valid_reg || out_ready;
  assign a_adv    = a_valid_reg && b_free;
  assign in_ready = (!a_valid_reg || a_adv) && !flush;
  assign accept   = in_valid && in_ready;

  // Legal opcodes are 0x00-0x04 and 0x06-0x08.
  assign a_illegal = (a_opcode_reg == 6'h05) || (a_opcode_reg > 6'h08);

`ifdef ALU_BYPASS_EN
  logic [REG_AW-1:0] rs_sel [2];
  logic [DATA_W-1:0] op_in  [2];
  logic [DATA_W-1:0] op_fwd [2];

  assign rs_sel[0] = in_rs0;
  assign rs_sel[1] = in_rs1;
  assign op_in[0]  = in_op0;
  assign op_in[1]  = in_op1;

  // The op leaving A this edge is newer than the one in B, so it wins.
  // a_adv already implies a_valid. Register 0 is never forwarded.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign op_fwd[gi] =
        (a_adv && (a_rd_reg == rs_sel[gi]) && (rs_sel[gi] != '0)) ? alu_result :
        (b_valid_reg && (b_rd_reg == rs_sel[gi]) && (rs_sel[gi] != '0)) ? b_result_reg :
        op_in[gi];
    end
  endgenerate

  assign cap_op0 = op_fwd[0];
  assign cap_op1 = op_fwd[1];
`else
  // Source indices have no function without forwarding.
  logic unused_rs;
  assign unused_rs = ^{in_rs0, in_rs1};

  assign cap_op0 = in_op0;
  assign cap_op1 = in_op1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_reg   <= 1'b0;
      a_opcode_reg  <= '0;
      a_op0_reg     <= '0;
      a_op1_reg     <= '0;
      a_rd_reg      <= '0;
      b_valid_reg   <= 1'b0;
      b_result_reg  <= '0;
      b_rd_reg      <= '0;
      b_illegal_reg <= 1'b0;
    end else if (flush) begin
      // Data registers keep their contents; only the valids matter.
      a_valid_reg <= 1'b0;
      b_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        a_valid_reg  <= 1'b1;
        a_opcode_reg <= in_opcode;
        a_op0_reg    <= cap_op0;
        a_op1_reg    <= cap_op1;
        a_rd_reg     <= in_rd;
      end else if (a_adv) begin
        a_valid_reg <= 1'b0;
      end

      if (a_adv) begin
        b_valid_reg   <= 1'b1;
        b_result_reg  <= alu_result;
        b_rd_reg      <= a_rd_reg;
        b_illegal_reg <= a_illegal;
      end else if (out_ready) begin
        b_valid_reg <= 1'b0;
      end
    end
  end

  assign alu_opcode    = a_opcode_reg;
  assign alu_operand_0 = a_op0_reg;
  assign alu_operand_1 = a_op1_reg;

  assign out_valid   = b_valid_reg;
  assign out_result  = b_result_reg;
  assign out_rd      = b_rd_reg;
  assign out_we      = (b_rd_reg != '0);
  assign out_illegal = b_illegal_reg;

endmodule
